// File: rtl/mem_access.sv
// Memory-access stage of the RV32I pipeline.
// Splits loads and stores into byte-serial transfers on an 8-bit memory port,
// assembles load results with sign/zero extension, and holds the upstream
// pipeline with a stall request until the access has finished.
module mem_access (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] rd_data_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        rd_write_enable_i,
  input  logic        load_enable_i,
  input  logic        store_enable_i,
  input  logic [31:0] load_store_addr_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ready_i,
  output logic [31:0] rd_data_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_write_enable_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [1:0]  cnt_nxt;
  logic [2:0]  len;
  logic [31:0] buffer;

  // Operands captured when an access is accepted; never reset, they are
  // always rewritten before use.
  logic [31:0] base;
  logic [31:0] sdata;
  logic [2:0]  f3;
  logic        is_store;

  logic        start;
  logic        last;

  // Byte count of an access from the size bits of funct3.
  function automatic logic [2:0] len_of(input logic [2:0] fn);
    case (fn[1:0])
      2'b00:   len_of = 3'd1;
      2'b01:   len_of = 3'd2;
      default: len_of = 3'd4;
    endcase
  endfunction

  // Sign- or zero-extend the assembled load word according to funct3.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  fn);
    logic signed [31:0] ext;
    case (fn[1:0])
      2'b00:   ext = fn[2] ? $signed({24'h000000, word[7:0]})
                           : $signed({{24{word[7]}}, word[7:0]});
      2'b01:   ext = fn[2] ? $signed({16'h0000, word[15:0]})
                           : $signed({{16{word[15]}}, word[15:0]});
      default: ext = $signed(word);
    endcase
    extend_load = ext;
  endfunction

  assign start = load_enable_i | store_enable_i;
  assign last  = ({1'b0, cnt} == (len - 3'd1));

  // Control registers: state, byte counter, length and load buffer.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      len    <= 3'd0;
      buffer <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) begin
        len    <= len_of(funct3_i);
        buffer <= 32'h0;
      end else if (state == BUSY && mem_ready_i && !is_store) begin
        buffer[{cnt, 3'b000} +: 8] <= mem_rdata_i;
      end
    end
  end

  // Operand capture at acceptance; a load wins over a simultaneous store.
  always_ff @(posedge clk_in) begin
    if (state == IDLE && start) begin
      base     <= load_store_addr_i;
      sdata    <= store_data_i;
      f3       <= funct3_i;
      is_store <= ~load_enable_i;
    end
  end

  // Next-state and byte-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = 2'd0;
        end
      end
      BUSY: begin
        if (mem_ready_i) begin
          if (last) state_nxt = DONE;
          else      cnt_nxt   = cnt + 2'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; everything is forced to zero while reset is asserted.
  always_comb begin
    mem_req_o         = 1'b0;
    mem_wr_o          = 1'b0;
    mem_addr_o        = 32'h0;
    mem_wdata_o       = 8'h00;
    rd_data_o         = 32'h0;
    rd_addr_o         = 5'd0;
    rd_write_enable_o = 1'b0;
    stall_req_o       = 1'b0;
    if (!rst_in) begin
      case (state)
        IDLE: begin
          if (start) begin
            stall_req_o = 1'b1;
          end else begin
            rd_data_o         = rd_data_i;
            rd_addr_o         = rd_addr_i;
            rd_write_enable_o = rd_write_enable_i;
          end
        end
        BUSY: begin
          mem_req_o   = 1'b1;
          mem_wr_o    = is_store;
          mem_addr_o  = base + {30'h0, cnt};
          mem_wdata_o = sdata[{cnt, 3'b000} +: 8];
          stall_req_o = 1'b1;
        end
        DONE: begin
          rd_addr_o = rd_addr_i;
          if (!is_store) begin
            rd_data_o         = extend_load(buffer, f3);
            rd_write_enable_o = rd_write_enable_i;
          end
        end
        default: begin
          stall_req_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: byte-serial memory model and
// arithmetic reference for load extension and store byte ordering.
module tb_mem_access;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] rd_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_write_enable_i;
  logic        load_enable_i;
  logic        store_enable_i;
  logic [31:0] load_store_addr_i;
  logic [31:0] store_data_i;
  logic [2:0]  funct3_i;
  logic        mem_req_o;
  logic        mem_wr_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_ready_i;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        rd_write_enable_o;
  logic        stall_req_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:4095];

  mem_access dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rd_data_i         (rd_data_i),
    .rd_addr_i         (rd_addr_i),
    .rd_write_enable_i (rd_write_enable_i),
    .load_enable_i     (load_enable_i),
    .store_enable_i    (store_enable_i),
    .load_store_addr_i (load_store_addr_i),
    .store_data_i      (store_data_i),
    .funct3_i          (funct3_i),
    .mem_req_o         (mem_req_o),
    .mem_wr_o          (mem_wr_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_rdata_i       (mem_rdata_i),
    .mem_ready_i       (mem_ready_i),
    .rd_data_o         (rd_data_o),
    .rd_addr_o         (rd_addr_o),
    .rd_write_enable_o (rd_write_enable_o),
    .stall_req_o       (stall_req_o)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    logic [11:0] idx;
    idx = a[11:0];
    return mem[idx];
  endfunction

  // Expected load result from the memory contents using plain arithmetic.
  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] fn);
    longint v;
    v = 0;
    if (fn[1:0] == 2'b00) begin
      v = rd_mem(a);
      if (!fn[2] && v >= 128) v = v - 256;
    end else if (fn[1:0] == 2'b01) begin
      v = rd_mem(a) + 256 * rd_mem(a + 1);
      if (!fn[2] && v >= 32768) v = v - 65536;
    end else begin
      v = rd_mem(a) + 256 * rd_mem(a + 1) + 65536 * rd_mem(a + 2)
          + 16777216 * longint'(rd_mem(a + 3));
    end
    return v[31:0];
  endfunction

  task automatic idle();
    load_enable_i  = 1'b0;
    store_enable_i = 1'b0;
    mem_ready_i    = 1'b0;
  endtask

  // Runs one memory operation starting at posedge+1; returns at posedge+1
  // after the DONE cycle with the op inputs still applied.
  // mode: 0 = ready always high, 1 = ready low every other cycle, 2 = random.
  task automatic do_op(input bit ld, input bit st, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [2:0] fn,
                       input logic [4:0] ra, input logic we, input int mode);
    int          n;
    logic [31:0] expv;
    logic [31:0] a;
    bit          st_eff;
    bit          got;
    int          waitc;
    n      = (fn[1:0] == 2'b00) ? 1 : (fn[1:0] == 2'b01) ? 2 : 4;
    st_eff = st & ~ld;
    expv   = exp_load(addr, fn);
    load_enable_i     = ld;
    store_enable_i    = st;
    load_store_addr_i = addr;
    store_data_i      = sd;
    funct3_i          = fn;
    rd_addr_i         = ra;
    rd_write_enable_i = we;
    rd_data_i         = $urandom;
    mem_ready_i       = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({mem_req_o, stall_req_o, rd_write_enable_o, rd_data_o} !== {1'b0, 1'b1, 1'b0, 32'h0})
      begin errors++; $display("FAIL op_accept: got req/stall/we/data %b%b%b %h required 010 00000000",
                               mem_req_o, stall_req_o, rd_write_enable_o, rd_data_o); end
    @(posedge clk_in); #1;
    for (int i = 0; i < n; i++) begin
      got   = 1'b0;
      waitc = 0;
      a     = addr + i;
      while (!got) begin
        if (mode == 0)      mem_ready_i = 1'b1;
        else if (mode == 1) mem_ready_i = (waitc % 2 == 1);
        else                mem_ready_i = (waitc >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rdata_i = rd_mem(mem_addr_o);
        @(negedge clk_in);
        checks++;
        if ({mem_req_o, mem_wr_o, mem_addr_o, stall_req_o, rd_write_enable_o} !==
            {1'b1, st_eff, a, 1'b1, 1'b0})
          begin errors++; $display("FAIL op_byte%0d: got req=%b wr=%b addr=%h stall=%b we=%b required 1 %b %h 1 0",
                                   i, mem_req_o, mem_wr_o, mem_addr_o, stall_req_o, rd_write_enable_o, st_eff, a); end
        if (st_eff) begin
          checks++;
          if (mem_wdata_o !== sd[8*i +: 8])
            begin errors++; $display("FAIL op_wdata%0d: got %h required %h", i, mem_wdata_o, sd[8*i +: 8]); end
          if (mem_ready_i) mem[mem_addr_o[11:0]] = mem_wdata_o;
        end
        got = mem_ready_i;
        waitc++;
        @(posedge clk_in); #1;
      end
    end
    mem_ready_i = 1'b0;
    @(negedge clk_in);
    checks++;
    if (st_eff) begin
      if ({mem_req_o, stall_req_o, rd_write_enable_o} !== 3'b000)
        begin errors++; $display("FAIL op_done_store: got req/stall/we %b%b%b required 000",
                                 mem_req_o, stall_req_o, rd_write_enable_o); end
    end else begin
      if ({mem_req_o, stall_req_o, rd_write_enable_o, rd_data_o, rd_addr_o} !==
          {1'b0, 1'b0, we, expv, ra})
        begin errors++; $display("FAIL op_done_load: got req=%b stall=%b we=%b data=%h rd=%0d required 0 0 %b %h %0d",
                                 mem_req_o, stall_req_o, rd_write_enable_o, rd_data_o, rd_addr_o, we, expv, ra); end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rd_data_i = 32'hDEADBEEF; rd_addr_i = 5'd7; rd_write_enable_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, stall_req_o, rd_data_o, rd_addr_o, rd_write_enable_o} !== 80'h0)
      begin errors++; $display("FAIL reset_idle: got data=%h rd=%0d we=%b stall=%b req=%b required all zero",
                               rd_data_o, rd_addr_o, rd_write_enable_o, stall_req_o, mem_req_o); end
    load_enable_i = 1'b1;
    #1;
    checks++;
    if ({stall_req_o, mem_req_o, rd_write_enable_o} !== 3'b000)
      begin errors++; $display("FAIL reset_load: got stall/req/we %b%b%b required 000",
                               stall_req_o, mem_req_o, rd_write_enable_o); end
    @(negedge clk_in);
    load_enable_i = 1'b0;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_passthrough();
    logic [31:0] d;
    logic [4:0]  r;
    logic        w;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin d = 32'h1234; r = 5'd5; w = 1'b1; end
      else begin d = $urandom; r = 5'($urandom); w = 1'($urandom); end
      rd_data_i = d; rd_addr_i = r; rd_write_enable_i = w;
      load_store_addr_i = $urandom;
      #1;
      checks++;
      if ({rd_data_o, rd_addr_o, rd_write_enable_o, stall_req_o, mem_req_o} !== {d, r, w, 1'b0, 1'b0})
        begin errors++; $display("FAIL passthrough%0d: got %h/%0d/%b stall=%b req=%b required %h/%0d/%b 0 0",
                                 k, rd_data_o, rd_addr_o, rd_write_enable_o, stall_req_o, mem_req_o, d, r, w); end
      @(posedge clk_in); #1;
    end
  endtask

  task automatic test_lw();
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    checks++;
    if (exp_load(32'h100, 3'b010) !== 32'h12345678)
      begin errors++; $display("FAIL lw_model: got %h required 12345678", exp_load(32'h100, 3'b010)); end
    do_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd3, 1'b1, 0);
    idle();
  endtask

  task automatic test_byte_half();
    mem[12'h200] = 8'h80;
    mem[12'h300] = 8'h00; mem[12'h301] = 8'h80;
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 3'b000, 5'd4, 1'b1, 0);
    idle();
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 3'b100, 5'd6, 1'b1, 0);
    idle();
    do_op(1'b1, 1'b0, 32'h300, 32'h0, 3'b001, 5'd8, 1'b1, 0);
    idle();
    do_op(1'b1, 1'b0, 32'h300, 32'h0, 3'b101, 5'd9, 1'b0, 1);
    idle();
  endtask

  task automatic test_sh_misaligned();
    mem[12'h201] = 8'h5A;
    do_op(1'b0, 1'b1, 32'h1FF, 32'hAABBCCDD, 3'b001, 5'd2, 1'b1, 1);
    idle();
    checks++;
    if ({mem[12'h1FF], mem[12'h200], mem[12'h201]} !== 24'hDDCC5A)
      begin errors++; $display("FAIL sh_mem: got %h %h %h required DD CC 5A",
                               mem[12'h1FF], mem[12'h200], mem[12'h201]); end
  endtask

  task automatic test_back_to_back();
    mem[12'h400] = 8'h11; mem[12'h401] = 8'h22; mem[12'h402] = 8'h33; mem[12'h403] = 8'hC4;
    do_op(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 5'd10, 1'b1, 0);
    do_op(1'b0, 1'b1, 32'h500, 32'h000000E7, 3'b000, 5'd11, 1'b0, 0);
    idle();
    checks++;
    if (mem[12'h500] !== 8'hE7)
      begin errors++; $display("FAIL b2b_sb: got %h required e7", mem[12'h500]); end
  endtask

  task automatic test_reset_mid();
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    load_enable_i = 1'b1; store_enable_i = 1'b0;
    load_store_addr_i = 32'h100; funct3_i = 3'b010;
    rd_addr_i = 5'd12; rd_write_enable_i = 1'b1;
    mem_ready_i = 1'b1;
    @(posedge clk_in); #1;
    mem_rdata_i = rd_mem(mem_addr_o);
    @(posedge clk_in); #1;
    mem_rdata_i = rd_mem(mem_addr_o);
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h101})
      begin errors++; $display("FAIL rstmid_pre: got req=%b addr=%h required 1 00000101", mem_req_o, mem_addr_o); end
    rst_in = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o, stall_req_o, rd_data_o, rd_addr_o, rd_write_enable_o} !== 80'h0)
      begin errors++; $display("FAIL rstmid_out: got req=%b addr=%h stall=%b data=%h required all zero",
                               mem_req_o, mem_addr_o, stall_req_o, rd_data_o); end
    @(negedge clk_in);
    idle();
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    rd_data_i = 32'hCAFE0001; rd_addr_i = 5'd13; rd_write_enable_i = 1'b1;
    #1;
    checks++;
    if ({rd_data_o, stall_req_o, mem_req_o} !== {32'hCAFE0001, 1'b0, 1'b0})
      begin errors++; $display("FAIL rstmid_idle: got data=%h stall=%b req=%b required cafe0001 0 0",
                               rd_data_o, stall_req_o, mem_req_o); end
    @(posedge clk_in); #1;
    do_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 5'd14, 1'b1, 0);
    idle();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [2:0]  fn;
    bit          ld, st;
    for (int k = 0; k < 14; k++) begin
      addr = (k == 0) ? 32'hFFFFFFFF : {20'h0, 12'($urandom)};
      fn   = 3'($urandom);
      ld   = 1'($urandom);
      st   = ~ld | (k % 5 == 0);
      do_op(ld, st, addr, $urandom, fn, 5'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      idle();
      if (k % 3 == 0) begin @(posedge clk_in); #1; end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    rst_in = 1'b1;
    rd_data_i = 32'h0; rd_addr_i = 5'd0; rd_write_enable_i = 1'b0;
    load_enable_i = 1'b0; store_enable_i = 1'b0;
    load_store_addr_i = 32'h0; store_data_i = 32'h0; funct3_i = 3'b000;
    mem_rdata_i = 8'h00; mem_ready_i = 1'b0;
    @(posedge clk_in); #1;
    test_reset();
    test_passthrough();
    test_lw();
    test_byte_half();
    test_sh_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
